// File: rtl/otter_if_stage_if.sv
// Signal bundle between the OTTER fetch stage, its instruction memory port,
// the hazard unit / EX redirect source and the decode stage.
interface otter_if_stage_if;
   // STALL freezes IF and IF/DE; REDIRECT (with REDIRECT_PC) wins over STALL.
   // IMEM_DOUT is valid the cycle after IMEM_ADDR is presented with IMEM_RDEN=1.
   logic        STALL;
   logic        REDIRECT;
   logic [31:0] REDIRECT_PC;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_RDEN;
   logic [31:0] IMEM_DOUT;
   logic [31:0] IF_DE_PC;
   logic [31:0] IF_DE_PC_INC;
   logic [31:0] IF_DE_IR;
   logic        IF_DE_VALID;

   modport master (
      input  STALL, REDIRECT, REDIRECT_PC, IMEM_DOUT,
      output IMEM_ADDR, IMEM_RDEN, IF_DE_PC, IF_DE_PC_INC, IF_DE_IR, IF_DE_VALID
   );

   modport slave (
      output STALL, REDIRECT, REDIRECT_PC, IMEM_DOUT,
      input  IMEM_ADDR, IMEM_RDEN, IF_DE_PC, IF_DE_PC_INC, IF_DE_IR, IF_DE_VALID
   );
endinterface

// File: rtl/otter_if_stage.sv
// Two-stage instruction fetch (F1 address, F2 data) feeding the IF/DE register,
// with a one-word skid buffer so a stall never loses the word already in flight.
module otter_if_stage #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
   input logic               CLK,
   input logic               RESET,
   otter_if_stage_if.master  bus
);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] pc;
   logic [31:0] f2_pc;
   logic        f2_valid;
   logic [31:0] hold_ir;
   logic        hold_valid;
   logic [31:0] de_pc;
   logic [31:0] de_pc_inc;
   logic [31:0] de_ir;
   logic        de_valid;
   logic [31:0] next_ir;

   // Memory is only read while the stage advances; a redirect always fetches.
   assign bus.IMEM_ADDR = pc;
   assign bus.IMEM_RDEN = !bus.STALL || bus.REDIRECT;

   // A word captured during a stall takes priority over the (stale) memory output.
   always_comb begin
      next_ir = NOP;
      if (f2_valid) begin
         next_ir = hold_valid ? hold_ir : bus.IMEM_DOUT;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pc         <= RESET_VEC;
         f2_pc      <= 32'h0000_0000;
         f2_valid   <= 1'b0;
         hold_ir    <= 32'h0000_0000;
         hold_valid <= 1'b0;
         de_pc      <= 32'h0000_0000;
         de_pc_inc  <= 32'h0000_0004;
         de_ir      <= NOP;
         de_valid   <= 1'b0;
      end else if (bus.REDIRECT) begin
         pc         <= {bus.REDIRECT_PC[31:2], 2'b00};
         f2_valid   <= 1'b0;
         hold_valid <= 1'b0;
         de_valid   <= 1'b0;
         de_ir      <= NOP;
      end else if (bus.STALL) begin
         if (f2_valid && !hold_valid) begin
            hold_ir    <= bus.IMEM_DOUT;
            hold_valid <= 1'b1;
         end
      end else begin
         de_ir      <= next_ir;
         de_pc      <= f2_pc;
         de_pc_inc  <= f2_pc + 32'd4;
         de_valid   <= f2_valid;
         f2_pc      <= pc;
         f2_valid   <= 1'b1;
         pc         <= pc + 32'd4;
         hold_valid <= 1'b0;
      end
   end

   assign bus.IF_DE_PC     = de_pc;
   assign bus.IF_DE_PC_INC = de_pc_inc;
   assign bus.IF_DE_IR     = de_ir;
   assign bus.IF_DE_VALID  = de_valid;
endmodule

// File: tb/tb_otter_if_stage.sv
// Bench for otter_if_stage: directed scenarios plus randomized stall/redirect
// traffic checked every cycle against an instruction-stream model.
module tb_otter_if_stage;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] MAIN_VEC = 32'h0000_0000;
   localparam logic [31:0] WRAP_VEC = 32'hFFFF_FFF8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // Expected IF/DE contents after each edge: {valid, pc, ir}.
   logic [64:0] exp_q[$];
   logic [31:0] m_start;
   logic [31:0] m_cnt;
   logic [64:0] m_last;

   otter_if_stage_if bus ();
   otter_if_stage_if bus2 ();

   otter_if_stage #(.RESET_VEC(MAIN_VEC)) dut (.CLK(clk), .RESET(rst), .bus(bus));
   otter_if_stage #(.RESET_VEC(WRAP_VEC)) dut_wrap (.CLK(clk), .RESET(rst), .bus(bus2));

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a;
   endfunction

   // Synchronous memory; unread cycles return garbage so a stale consume shows up.
   always @(posedge clk) begin
      bus.IMEM_DOUT  <= bus.IMEM_RDEN  ? mem_word(bus.IMEM_ADDR)  : $urandom;
      bus2.IMEM_DOUT <= bus2.IMEM_RDEN ? mem_word(bus2.IMEM_ADDR) : $urandom;
   end

   // The n-th advancing edge since a restart shows the instruction at start+4*(n-2).
   function automatic logic [64:0] entry_for(input logic [31:0] start, input logic [31:0] n);
      logic [31:0] p;
      if (n >= 32'd2) begin
         p = start + ((n - 32'd2) << 2);
         return {1'b1, p, mem_word(p)};
      end
      return {1'b0, 32'h0000_0000, NOP};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_start <= MAIN_VEC;
         m_cnt   <= 32'd0;
         m_last  <= {1'b0, 32'h0000_0000, NOP};
         exp_q.delete();
      end else if (bus.REDIRECT) begin
         m_start <= {bus.REDIRECT_PC[31:2], 2'b00};
         m_cnt   <= 32'd0;
         m_last  <= {1'b0, m_last[63:32], NOP};
         exp_q.push_back({1'b0, m_last[63:32], NOP});
      end else if (bus.STALL) begin
         exp_q.push_back(m_last);
      end else begin
         m_cnt  <= m_cnt + 32'd1;
         m_last <= entry_for(m_start, m_cnt + 32'd1);
         exp_q.push_back(entry_for(m_start, m_cnt + 32'd1));
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      logic [64:0] e;
      if (!rst) begin
         chk("imem_addr", bus.IMEM_ADDR, m_start + (m_cnt << 2));
         chk("imem_rden", {31'b0, bus.IMEM_RDEN}, {31'b0, !(bus.STALL && !bus.REDIRECT)});
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("if_de_valid", {31'b0, bus.IF_DE_VALID}, {31'b0, e[64]});
            chk("if_de_ir", bus.IF_DE_IR, e[31:0]);
            if (e[64]) begin
               chk("if_de_pc", bus.IF_DE_PC, e[63:32]);
               chk("if_de_pc_inc", bus.IF_DE_PC_INC, e[63:32] + 32'd4);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_de(input string name, input logic v, input logic [31:0] p, input logic [31:0] ir);
      chk({name, "_valid"}, {31'b0, bus.IF_DE_VALID}, {31'b0, v});
      chk({name, "_ir"}, bus.IF_DE_IR, ir);
      if (v) begin
         chk({name, "_pc"}, bus.IF_DE_PC, p);
         chk({name, "_pc_inc"}, bus.IF_DE_PC_INC, p + 32'd4);
      end
   endtask

   initial begin
      #500000;
      errors++;
      $display("FAIL timeout actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      bool_found_init();
   end

   task automatic bool_found_init();
      bit found;
      bus.STALL = 1'b0; bus.REDIRECT = 1'b0; bus.REDIRECT_PC = 32'h0;
      bus2.STALL = 1'b0; bus2.REDIRECT = 1'b0; bus2.REDIRECT_PC = 32'h0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset values and first fetches.
      chk("rst_pc", bus.IF_DE_PC, 32'h0);
      chk("rst_pc_inc", bus.IF_DE_PC_INC, 32'h4);
      chk("rst_ir", bus.IF_DE_IR, NOP);
      chk("rst_valid", {31'b0, bus.IF_DE_VALID}, 32'h0);
      chk("rst_addr", bus.IMEM_ADDR, 32'h0);
      chk("wrap_rst_addr", bus2.IMEM_ADDR, WRAP_VEC);
      tick();
      chk("e1_addr", bus.IMEM_ADDR, 32'h4);
      chk("e1_valid", {31'b0, bus.IF_DE_VALID}, 32'h0);
      tick();
      chk("e2_addr", bus.IMEM_ADDR, 32'h8);
      chk_de("e2", 1'b1, 32'h0, 32'h0);
      chk("wrap_e2_pc", bus2.IF_DE_PC, 32'hFFFF_FFF8);
      tick();
      chk("wrap_e3_pc", bus2.IF_DE_PC, 32'hFFFF_FFFC);
      tick();
      chk("wrap_e4_pc", bus2.IF_DE_PC, 32'h0000_0000);
      chk("wrap_e4_pc_inc", bus2.IF_DE_PC_INC, 32'h0000_0004);

      // Three-cycle stall with 0x10 in IF/DE.
      repeat (2) tick();
      chk_de("pre_stall", 1'b1, 32'h10, 32'h10);
      bus.STALL = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_de("stall_frozen", 1'b1, 32'h10, 32'h10);
         chk("stall_rden", {31'b0, bus.IMEM_RDEN}, 32'h0);
      end
      bus.STALL = 1'b0;
      tick();
      chk_de("post_stall0", 1'b1, 32'h14, 32'h14);
      tick();
      chk_de("post_stall1", 1'b1, 32'h18, 32'h18);

      // Redirect to a misaligned target from pc=0x40.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (bus.IMEM_ADDR == 32'h40) found = 1'b1;
         else tick();
      end
      chk("reach_pc40", bus.IMEM_ADDR, 32'h40);
      bus.REDIRECT = 1'b1; bus.REDIRECT_PC = 32'h103;
      tick();
      bus.REDIRECT = 1'b0;
      chk("redir_addr", bus.IMEM_ADDR, 32'h100);
      chk_de("redir_e0", 1'b0, 32'h0, NOP);
      tick();
      chk_de("redir_e1", 1'b0, 32'h0, NOP);
      tick();
      chk_de("redir_e2", 1'b1, 32'h100, 32'h100);

      // Redirect and stall together while the skid buffer is full.
      repeat (3) tick();
      bus.STALL = 1'b1;
      tick();
      bus.REDIRECT = 1'b1; bus.REDIRECT_PC = 32'h200;
      tick();
      bus.REDIRECT = 1'b0; bus.STALL = 1'b0;
      chk("rs_addr", bus.IMEM_ADDR, 32'h200);
      chk_de("rs_e0", 1'b0, 32'h0, NOP);
      tick();
      chk_de("rs_e1", 1'b0, 32'h0, NOP);
      tick();
      chk_de("rs_e2", 1'b1, 32'h200, 32'h200);

      // Random traffic, with some targets near the top of the address space.
      for (int i = 0; i < 1500; i++) begin
         bus.STALL = ($urandom_range(0, 3) == 0);
         bus.REDIRECT = ($urandom_range(0, 19) == 0);
         bus.REDIRECT_PC = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
         tick();
      end
      bus.STALL = 1'b0; bus.REDIRECT = 1'b0;
      repeat (4) tick();

      // Asynchronous reset in the middle of a stall with the skid buffer loaded.
      bus.STALL = 1'b1;
      repeat (2) tick();
      #2 rst = 1'b1;
      #1;
      chk("async_valid", {31'b0, bus.IF_DE_VALID}, 32'h0);
      chk("async_ir", bus.IF_DE_IR, NOP);
      chk("async_pc", bus.IF_DE_PC, 32'h0);
      chk("async_pc_inc", bus.IF_DE_PC_INC, 32'h4);
      chk("async_addr", bus.IMEM_ADDR, MAIN_VEC);
      @(posedge clk);
      #1 rst = 1'b0;
      bus.STALL = 1'b0;
      tick();
      chk("after_rst_e1_valid", {31'b0, bus.IF_DE_VALID}, 32'h0);
      tick();
      chk_de("after_rst_e2", 1'b1, MAIN_VEC, mem_word(MAIN_VEC));
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask
endmodule
